// File: rtl/serial_rxtx_fifo_pkg.sv
// Shared encodings and divider math for the serial echo/control block.
package serial_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'd0,
    MODE_INC  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_NONE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Rounded integer division used for both baud dividers.
  function automatic int divRound(input int num, input int den);
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/serial_rxtx_fifo_fifo.sv
// Small synchronous byte FIFO; push on full is accepted only alongside a pop.
module serial_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      level <= level + 1'b1;
      else if (doPop && !doPush) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/serial_rxtx_fifo.sv
// Oversampling UART RX -> transform -> byte FIFO -> UART TX, with sticky error flags.
module serial_rxtx_fifo import serial_pkg::*; #(
  parameter int CLK_FREQ   = 24000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int INC        = 1,
  parameter int LED_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rxd,
  output logic                        txd,
  input  logic [1:0]                  mode,
  input  logic                        tx_en,
  input  logic                        err_clr,
  output logic [LED_W-1:0]            led,
  output logic                        rx_frame_err,
  output logic                        fifo_overflow,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int RX_DIV = divRound(CLK_FREQ, BAUD * OVERSAMPLE);
  localparam int TX_DIV = divRound(CLK_FREQ, BAUD);
  localparam int RXW = $clog2(RX_DIV + 1);
  localparam int TXW = $clog2(TX_DIV + 1);
  localparam int OSW = $clog2(OVERSAMPLE + 1);
  localparam int BW  = $clog2(DATA_BITS + 1);

  // RX front end
  logic [1:0]     rxSync;
  logic           rxS, rxTick;
  logic [RXW-1:0] rxDivCnt;

  assign rxS    = rxSync[1];
  assign rxTick = (rxDivCnt == RXW'(RX_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxSync   <= 2'b11;
      rxDivCnt <= '0;
    end else begin
      rxSync   <= {rxSync[0], rxd};
      rxDivCnt <= rxTick ? '0 : rxDivCnt + 1'b1;
    end
  end

  rx_state_e            rxState;
  logic [OSW-1:0]       rxSmp;
  logic [BW-1:0]        rxBit;
  logic [DATA_BITS-1:0] rxShift;
  logic                 rxValid, rxWaitHigh, rxErrEvt;

  assign rxErrEvt = rxTick && (rxState == RX_STOP) &&
                    (rxSmp == OSW'(OVERSAMPLE - 1)) && !rxS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState    <= RX_IDLE;
      rxSmp      <= '0;
      rxBit      <= '0;
      rxShift    <= '0;
      rxValid    <= 1'b0;
      rxWaitHigh <= 1'b0;
    end else begin
      rxValid <= 1'b0;
      if (rxTick) begin
        unique case (rxState)
          RX_IDLE: begin
            rxSmp <= '0;
            // After a framing error the line must go idle before a new start bit counts.
            if (rxWaitHigh) rxWaitHigh <= !rxS;
            else if (!rxS)  rxState    <= RX_START;
          end
          RX_START: begin
            if (rxSmp == OSW'(OVERSAMPLE / 2 - 1)) begin
              rxSmp   <= '0;
              rxBit   <= '0;
              rxState <= rxS ? RX_IDLE : RX_DATA;
            end else rxSmp <= rxSmp + 1'b1;
          end
          RX_DATA: begin
            if (rxSmp == OSW'(OVERSAMPLE - 1)) begin
              rxSmp   <= '0;
              rxShift <= {rxS, rxShift[DATA_BITS-1:1]};
              if (rxBit == BW'(DATA_BITS - 1)) rxState <= RX_STOP;
              else rxBit <= rxBit + 1'b1;
            end else rxSmp <= rxSmp + 1'b1;
          end
          RX_STOP: begin
            if (rxSmp == OSW'(OVERSAMPLE - 1)) begin
              rxSmp      <= '0;
              rxValid    <= rxS;
              rxWaitHigh <= !rxS;
              rxState    <= RX_IDLE;
            end else rxSmp <= rxSmp + 1'b1;
          end
        endcase
      end
    end
  end

  // Transform and FIFO
  logic [DATA_BITS-1:0] xfData, fifoDout;
  logic                 push, pop, fifoFull, fifoEmpty;

  always_comb begin
    xfData = rxShift;
    case (mode_e'(mode))
      MODE_INC: xfData = rxShift + DATA_BITS'(INC);
      MODE_INV: xfData = ~rxShift;
      default:  ;
    endcase
  end

  assign push = rxValid && (mode_e'(mode) != MODE_NONE);

  serial_byte_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (xfData),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led           <= '0;
      rx_frame_err  <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      if (rxValid) led <= rxShift[LED_W-1:0];
      if (rxErrEvt)     rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
      if (push && fifoFull && !pop) fifo_overflow <= 1'b1;
      else if (err_clr)             fifo_overflow <= 1'b0;
    end
  end

  // TX: txd/tx_busy are registered, so they trail the state by one clk throughout.
  tx_state_e            txState;
  logic [TXW-1:0]       txCnt;
  logic [BW-1:0]        txBit;
  logic [DATA_BITS-1:0] txShift;
  logic                 txBitEnd;

  assign txBitEnd = (txCnt == TXW'(TX_DIV - 1));
  // Popping in the last stop-bit clk lets frames run back to back with no idle bit.
  assign pop = tx_en && !fifoEmpty &&
               ((txState == TX_IDLE) || ((txState == TX_STOP) && txBitEnd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState <= TX_IDLE;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      txCnt <= txBitEnd ? '0 : txCnt + 1'b1;
      unique case (txState)
        TX_IDLE: begin
          txd     <= 1'b1;
          tx_busy <= 1'b0;
          txCnt   <= '0;
          if (pop) begin
            txShift <= fifoDout;
            txState <= TX_START;
          end
        end
        TX_START: begin
          txd     <= 1'b0;
          tx_busy <= 1'b1;
          if (txBitEnd) begin
            txBit   <= '0;
            txState <= TX_DATA;
          end
        end
        TX_DATA: begin
          txd     <= txShift[0];
          tx_busy <= 1'b1;
          if (txBitEnd) begin
            txShift <= txShift >> 1;
            if (txBit == BW'(DATA_BITS - 1)) txState <= TX_STOP;
            else txBit <= txBit + 1'b1;
          end
        end
        TX_STOP: begin
          txd     <= 1'b1;
          tx_busy <= 1'b1;
          if (txBitEnd) begin
            if (pop) begin
              txShift <= fifoDout;
              txState <= TX_START;
            end else txState <= TX_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rxtx_fifo.sv
// Directed bench for serial_rxtx_fifo at default parameters (208 clks per bit both ways).
module tb_serial_rxtx_fifo;

  localparam int BIT_CLKS = 208;

  logic       clk, rst_n, rxd, txd, tx_en, err_clr;
  logic [1:0] mode, led;
  logic       rx_frame_err, fifo_overflow, tx_busy;
  logic [2:0] fifo_level;

  serial_rxtx_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .txd           (txd),
    .mode          (mode),
    .tx_en         (tx_en),
    .err_clr       (err_clr),
    .led           (led),
    .rx_frame_err  (rx_frame_err),
    .fifo_overflow (fifo_overflow),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX line monitor: decodes frames by mid-bit sampling, records start-bit low run.
  logic [7:0] monData[$];
  int         monLow[$];
  int         monStart[$];
  logic       monStop[$];

  initial begin : monitor
    logic [7:0] b;
    logic       stp;
    int         low, t0;
    bit         high, aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        t0 = cyc; low = 1; high = 0; aborted = 0; b = '0; stp = 1'b0;
        for (int i = 1; i <= 104 + 9 * BIT_CLKS; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin aborted = 1; break; end
          if (!high) begin
            if (txd === 1'b0) low++;
            else high = 1;
          end
          if (i % BIT_CLKS == 104 && i > 104) begin
            if ((i - 104) / BIT_CLKS <= 8) b[(i - 104) / BIT_CLKS - 1] = txd;
            else stp = txd;
          end
        end
        if (!aborted) begin
          monData.push_back(b);
          monLow.push_back(low);
          monStart.push_back(t0);
          monStop.push_back(stp);
        end
      end
    end
  end

  bit sawZero, sawSet;

  task automatic sendByte(input logic [7:0] b, input logic stopBit, input logic holdClr);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stopBit;
    if (holdClr) begin err_clr = 1'b1; sawZero = 0; sawSet = 0; end
    repeat (BIT_CLKS) begin
      @(negedge clk);
      if (holdClr && err_clr) begin
        if (!rx_frame_err) sawZero = 1;
        else if (sawZero) begin err_clr = 1'b0; sawSet = 1; end
      end
    end
    rxd = 1'b1;
    err_clr = 1'b0;
  endtask

  task automatic waitFrames(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && monData.size() < n; i++) @(negedge clk);
    check(tag, monData.size(), n);
  endtask

  int base, lowCnt;

  initial begin
    rxd = 1'b1; mode = 2'd0; tx_en = 1'b0; err_clr = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_led", led, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovf", fifo_overflow, 0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // mode 1: 0x41 -> 0x42
    mode = 2'd1; tx_en = 1'b1;
    sendByte(8'h41, 1'b1, 1'b0);
    check("t1_led", led, 2'b01);
    waitFrames("t1_wait", 1, 2500);
    check("t1_echo", monData[0], 8'h42);
    check("t1_startlow", monLow[0], 2 * BIT_CLKS);
    check("t1_stop", monStop[0], 1);
    check("t1_ferr", rx_frame_err, 0);
    check("t1_ovf", fifo_overflow, 0);

    // mode 2 invert, mode 1 wrap
    mode = 2'd2;
    sendByte(8'h0F, 1'b1, 1'b0);
    waitFrames("t2_wait", 2, 2500);
    check("t2_echo", monData[1], 8'hF0);
    mode = 2'd1;
    sendByte(8'hFF, 1'b1, 1'b0);
    check("t3_led", led, 2'b11);
    waitFrames("t3_wait", 3, 2500);
    check("t3_echo", monData[2], 8'h00);

    // mode 3: no echo, led still updates
    mode = 2'd3;
    sendByte(8'h55, 1'b1, 1'b0);
    check("t4_led", led, 2'b01);
    check("t4_level", fifo_level, 0);
    lowCnt = 0;
    repeat (2500) begin @(negedge clk); if (txd !== 1'b1) lowCnt++; end
    check("t4_txd_idle", lowCnt, 0);
    check("t4_frames", monData.size(), 3);

    // overflow: 5 bytes into a 4-deep FIFO with TX gated
    mode = 2'd0; tx_en = 1'b0;
    for (int i = 1; i <= 5; i++) sendByte(8'(i), 1'b1, 1'b0);
    check("t5_level", fifo_level, 4);
    check("t5_ovf", fifo_overflow, 1);
    base = monData.size();
    tx_en = 1'b1;
    waitFrames("t5_wait", base + 4, 10000);
    for (int i = 0; i < 4; i++) check("t5_echo", monData[base + i], 32'(i + 1));
    check("t5_b2b", monStart[base + 1] - monStart[base], 10 * BIT_CLKS);
    repeat (2500) @(negedge clk);
    check("t5_no5th", monData.size(), base + 4);
    check("t5_level0", fifo_level, 0);

    // framing errors and clear priority
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("t6_ovf_clr", fifo_overflow, 0);
    base = monData.size();
    sendByte(8'hA6, 1'b0, 1'b0);
    check("t6_ferr", rx_frame_err, 1);
    check("t6_led", led, 2'b01);
    check("t6_level", fifo_level, 0);
    repeat (300) @(negedge clk);
    check("t6_busy", tx_busy, 0);
    check("t6_frames", monData.size(), base);
    sendByte(8'h3C, 1'b0, 1'b1);
    check("t6_setwins", sawSet, 1);
    repeat (5) @(negedge clk);
    check("t6_ferr_held", rx_frame_err, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("t6_ferr_clr", rx_frame_err, 0);
    repeat (300) @(negedge clk);

    // 3-clk glitch, then a clean 0x33
    rxd = 1'b0; repeat (3) @(negedge clk); rxd = 1'b1;
    repeat (400) @(negedge clk);
    check("t7_level", fifo_level, 0);
    check("t7_busy", tx_busy, 0);
    check("t7_frames", monData.size(), base);
    sendByte(8'h33, 1'b1, 1'b0);
    check("t7_led", led, 2'b11);
    waitFrames("t7_wait", base + 1, 2500);
    check("t7_echo", monData[base], 8'h33);
    repeat (300) @(negedge clk);

    // reset in the middle of a TX data bit with two bytes queued
    tx_en = 1'b0;
    sendByte(8'h10, 1'b1, 1'b0);
    sendByte(8'h20, 1'b1, 1'b0);
    check("t8_level", fifo_level, 2);
    base = monData.size();
    tx_en = 1'b1;
    for (int i = 0; i < 200 && txd !== 1'b0; i++) @(negedge clk);
    repeat (300) @(negedge clk);
    check("t8_pre_txd", txd, 0);
    rst_n = 1'b0;
    #1;
    check("t8_txd", txd, 1);
    check("t8_busy", tx_busy, 0);
    check("t8_level", fifo_level, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lowCnt = 0;
    repeat (3000) begin @(negedge clk); if (txd !== 1'b1 || tx_busy !== 1'b0) lowCnt++; end
    check("t8_quiet", lowCnt, 0);
    check("t8_frames", monData.size(), base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_rxtx_fifo.md
Name: serial_rxtx_fifo

Overview:
Parametrised serial echo/control block, the next generation of the basic serial RxTx loopback. It contains an oversampling UART receiver, a transform stage, an RX-to-TX byte FIFO and a UART transmitter. It adds several things the loopback lacks: echo modes, TX gating, buffering of back-to-back characters, and sticky error reporting. It sits between the board serial pins (FTDI/MAX232 adaptor) and the status LEDs.

Parameters:
CLK_FREQ, 24000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
OVERSAMPLE, 16, RX samples per bit; must be even and at least 8
DATA_BITS, 8, character length, 5..8, LSB first, no parity, 1 stop bit
FIFO_DEPTH, 4, FIFO entries; must be a power of two and at least 2
INC, 1, addend used in mode 1
LED_W, 2, LED register width; must be at most DATA_BITS

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rxd  in  1  serial input, asynchronous, idle high
txd  out  1  serial output, idle high
mode  in  2  0 = raw echo, 1 = echo + INC, 2 = echo bitwise-inverted, 3 = no echo
tx_en  in  1  when 1, TX may pop the FIFO
err_clr  in  1  single-cycle clear of the sticky flags
led  out  LED_W  low bits of the last valid received character
rx_frame_err  out  1  sticky; set when a stop bit is sampled as 0
fifo_overflow  out  1  sticky; set when a push to a full FIFO is dropped
tx_busy  out  1  high while a TX frame is in progress
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous assert, synchronous release): txd = 1, tx_busy = 0, led = 0, both flags = 0, fifo_level = 0, FIFO pointers = 0, RX and TX state = IDLE. Reset mid-frame aborts the frame and txd returns to 1 immediately.
- Baud dividers (integer, rounded):
  - RX_DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE); 13 at defaults.
  - TX_DIV = (CLK_FREQ + BAUD/2) / BAUD; 208 at defaults.
  - The RX tick counter free-runs. The TX bit counter restarts at the start of each frame.
- RX input path: rxd passes through a 2-flop synchroniser before use.
- RX state machine, stepped on RX ticks:
  - IDLE to START on a synchronised 0.
  - START: after OVERSAMPLE/2 ticks, resample. 0 goes to DATA; 1 is a glitch and returns to IDLE with no side effect.
  - DATA: sample every OVERSAMPLE ticks, DATA_BITS times, LSB first.
  - STOP: sample after OVERSAMPLE ticks.
    - 1: assert an internal valid strobe for exactly one clk, then return to IDLE.
    - 0: set rx_frame_err, discard the character, then wait in IDLE for rxd = 1 before the next START is accepted.
- On the valid strobe clk edge:
  - led <= data[LED_W-1:0], in every mode.
  - Push the transformed character unless mode = 3.
  - Transform is modulo 2^DATA_BITS:
    - mode 0: data
    - mode 1: data + INC, wrapping (0xFF + 1 = 0x00 at 8 bits)
    - mode 2: ~data
  - mode is sampled on the strobe cycle.
- FIFO behaviour:
  - Push to a full FIFO with no simultaneous pop: the character is dropped and fifo_overflow is set.
  - Push and pop on the same cycle: both occur and the level is unchanged, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH.
- TX state machine, IDLE to START to DATA to STOP to IDLE, each bit lasting TX_DIV clks:
  - In IDLE, when tx_en = 1 and the FIFO is not empty: pop, load the shift register, and drive txd = 0 on the next clk.
  - tx_busy = 1 from that clk until the end of the stop bit.
  - Back-to-back frames carry no extra idle bit.
  - Dropping tx_en mid-frame completes the current frame and blocks further pops.
- Sticky flags: err_clr clears both flags. If a set event and err_clr occur on the same cycle, the set wins.
- Latency:
  - Stop-bit sample to FIFO write: 1 clk.
  - FIFO write to txd falling edge: 2 clks when TX is idle and tx_en = 1.

Decomposition:
- Package serial_pkg holds:
  - mode encodings MODE_RAW, MODE_INC, MODE_INV, MODE_NONE;
  - the RX/TX state enums;
  - a constant function computing the rounded dividers.
- Sub-module serial_byte_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty/level, and an async active-low reset.

Test Plan:
- Defaults, mode = 1, tx_en = 1, send 0x41 -> txd returns 0x42 with 1 stop bit, bit period 208 clks, led = 2'b01, no flags set.
- mode = 2, send 0x0F -> 0xF0 echoed; mode = 1, send 0xFF -> 0x00 echoed; mode = 3, send 0x55 -> txd stays 1, led = 2'b01, fifo_level = 0.
- tx_en = 0, send 5 bytes 0x01..0x05 -> fifo_level = 4 and fifo_overflow = 1; then tx_en = 1 -> 0x01..0x04 echoed in order (mode 0) and 0x05 is never sent.
- Frame with stop bit = 0 -> rx_frame_err = 1, no push, led unchanged; pulse err_clr on the same cycle as a new frame error -> flag stays 1.
- Drive a 3-clk low glitch on rxd -> no strobe, no push, RX back in IDLE; the next valid 0x33 is received correctly.
- Assert rst_n = 0 mid-TX data bit with 2 bytes queued -> txd = 1, tx_busy = 0, fifo_level = 0 immediately; after release, no residual transmission.
